// File: rtl/prefix_adder_checker_if.sv
// Operand/result bus between the adder checker and the adder under test.
// The master drives a/b/cin and the slave returns s/cout.
interface prefix_adder_checker_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] a_out;
    logic [WIDTH-1:0] b_out;
    logic             cin_out;
    logic [WIDTH-1:0] s_in;
    logic             cout_in;

    modport master (
        output a_out,
        output b_out,
        output cin_out,
        input  s_in,
        input  cout_in
    );

    modport slave (
        input  a_out,
        input  b_out,
        input  cin_out,
        output s_in,
        output cout_in
    );
endinterface

// File: rtl/prefix_adder_checker.sv
// Stimulus source and result sink for the prefix adder: directed + LFSR vectors,
// delayed expected-sum pipeline, error counting and pass/done status.
module prefix_adder_checker #(
    parameter int          WIDTH       = 32,
    parameter int          LATENCY     = 1,
    parameter int          NUM_VECTORS = 256,
    parameter logic [31:0] SEED        = 32'hACE12345
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    prefix_adder_checker_if.master bus,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output logic [15:0]            vec_count,
    output logic [15:0]            err_count,
    output logic [15:0]            first_err_idx
);
    localparam int               TOTAL     = 4 + NUM_VECTORS;
    localparam logic [15:0]      LAST      = 16'(TOTAL - 1);
    localparam logic [15:0]      NONE      = 16'hFFFF;
    localparam logic [31:0]      TAPS      = 32'h80200003;
    localparam logic [31:0]      XMASK     = 32'h5A5A5A5A;
    localparam logic [WIDTH-1:0] ONES      = '1;
    localparam logic [WIDTH-1:0] HALF      = ONES >> 1;
    localparam logic [3:0]       DRAIN_LEN = 4'(LATENCY + 1);

    typedef enum logic [2:0] {
        IDLE,
        DIRECTED,
        RANDOM,
        DRAIN,
        DONE
    } state_t;

    typedef struct packed {
        logic             valid;
        logic [WIDTH:0]   sum;
        logic [15:0]      idx;
    } exp_t;

    state_t           state;
    logic [31:0]      lfsr;
    logic [31:0]      rev;
    logic [31:0]      lfsr_step;
    logic [3:0]       drain_cnt;
    exp_t             pipe [LATENCY+1];
    exp_t             tail;

    logic             accept;
    logic             issue;
    logic             is_rand;
    logic [15:0]      idx;
    logic [WIDTH-1:0] nxt_a;
    logic [WIDTH-1:0] nxt_b;
    logic             nxt_c;
    logic [WIDTH:0]   nxt_sum;
    logic [WIDTH:0]   obs;
    logic             mism;

    assign accept  = start && (state == IDLE || state == DONE);
    assign is_rand = !accept && state == RANDOM;
    assign issue   = accept || state == DIRECTED || state == RANDOM;
    assign idx     = accept ? 16'd0 : vec_count;

    always_comb begin
        rev = '0;
        for (int i = 0; i < 32; i++) begin
            rev[i] = lfsr[31-i];
        end
    end

    assign lfsr_step = (lfsr >> 1) ^ (lfsr[0] ? TAPS : 32'd0);

    // Vector index selects the directed set; everything past it is LFSR driven.
    always_comb begin
        nxt_a = '0;
        nxt_b = '0;
        nxt_c = 1'b0;
        unique case (1'b1)
            is_rand: begin
                nxt_a = lfsr[WIDTH-1:0];
                nxt_b = rev[WIDTH-1:0] ^ XMASK[WIDTH-1:0];
                nxt_c = lfsr[31] ^ lfsr[0];
            end
            (idx == 16'd1): begin
                nxt_a = ONES;
                nxt_b = {{(WIDTH-1){1'b0}}, 1'b1};
            end
            (idx == 16'd2): begin
                nxt_a = HALF;
                nxt_b = {{(WIDTH-1){1'b0}}, 1'b1};
            end
            (idx == 16'd3): begin
                nxt_a = ONES;
                nxt_b = ONES;
                nxt_c = 1'b1;
            end
            default: ;
        endcase
    end

    assign nxt_sum = {1'b0, nxt_a} + {1'b0, nxt_b}
                   + {{WIDTH{1'b0}}, nxt_c};

    assign tail = pipe[LATENCY];
    assign obs  = {bus.cout_in, bus.s_in};
    assign mism = tail.valid && (obs != tail.sum);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            lfsr          <= SEED;
            drain_cnt     <= '0;
            bus.a_out     <= '0;
            bus.b_out     <= '0;
            bus.cin_out   <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            pass          <= 1'b0;
            vec_count     <= '0;
            err_count     <= '0;
            first_err_idx <= NONE;
            for (int i = 0; i <= LATENCY; i++) begin
                pipe[i] <= '0;
            end
        end else begin
            pipe[0].valid <= issue;
            pipe[0].sum   <= nxt_sum;
            pipe[0].idx   <= idx;
            for (int i = 1; i <= LATENCY; i++) begin
                pipe[i] <= pipe[i-1];
            end

            if (mism) begin
                if (err_count != NONE) begin
                    err_count <= err_count + 16'd1;
                end
                if (first_err_idx == NONE) begin
                    first_err_idx <= tail.idx;
                end
            end

            if (issue) begin
                bus.a_out   <= nxt_a;
                bus.b_out   <= nxt_b;
                bus.cin_out <= nxt_c;
                vec_count   <= idx + 16'd1;
            end

            if (is_rand) begin
                lfsr <= lfsr_step;
            end

            // Start clears results after the compare above so it always wins.
            unique case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state         <= DIRECTED;
                        lfsr          <= SEED;
                        err_count     <= '0;
                        first_err_idx <= NONE;
                        busy          <= 1'b1;
                        done          <= 1'b0;
                        pass          <= 1'b0;
                    end
                end
                DIRECTED: begin
                    if (vec_count == 16'd3) begin
                        state <= RANDOM;
                    end
                end
                RANDOM: begin
                    if (vec_count == LAST) begin
                        state     <= DRAIN;
                        drain_cnt <= '0;
                    end
                end
                DRAIN: begin
                    bus.a_out   <= '0;
                    bus.b_out   <= '0;
                    bus.cin_out <= 1'b0;
                    if (drain_cnt == DRAIN_LEN) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (err_count == 16'd0);
                    end else begin
                        drain_cnt <= drain_cnt + 4'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule
